// File: rtl/door_exit_ctrl_if.sv
// rtl/door_exit_ctrl_if.sv - door exit controller control/status bundle (reach, pause, restart in; frames, completion, timer out)
interface door_exit_ctrl_if #(
    parameter int NUM_FRAMES = 4
);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic          reach [2];
    logic          pause;
    logic          level_restart;
    logic [FW-1:0] door_frame [2];
    logic          level_done;
    logic          complete;
    logic [9:0]    elapsed_sec;

    modport master (
        output reach, pause, level_restart,
        input  door_frame, level_done, complete, elapsed_sec
    );

    modport slave (
        input  reach, pause, level_restart,
        output door_frame, level_done, complete, elapsed_sec
    );
endinterface

// File: rtl/door_exit_ctrl.sv
// rtl/door_exit_ctrl.sv - per-door open/close animation and level completion FSM (option macro LEVEL_TIMER_EN adds elapsed_sec timer)
module door_exit_ctrl #(
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_DIV   = 8,
    parameter int HOLD_FRAMES = 30
) (
    input  logic             frame_clk,
    input  logic             RESET,
    door_exit_ctrl_if.slave  bus
);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int DW = $clog2(FRAME_DIV + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [FW-1:0] FRAME_MAX = FW'(NUM_FRAMES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(FRAME_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    typedef enum logic {PLAY, DONE} state_t;

    state_t        state_q;
    logic [FW-1:0] frame_q   [2];
    logic [FW-1:0] frame_nxt [2];
    logic [DW-1:0] div_q     [2];
    logic [DW-1:0] div_nxt   [2];
    logic          reach_q   [2];
    logic          opening   [2];
    logic          closing   [2];
    logic [HW-1:0] hold_q;
    logic          hold_ok;
    logic          level_done_q;
    logic          complete_q;

    // Next frame/divider per door. A reach change only restarts the step
    // when a step is actually in progress (div != 0); otherwise the change
    // tick is the first tick of the new step, giving exactly FRAME_DIV ticks
    // from reach edge to the first frame change.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            frame_nxt[i] = frame_q[i];
            div_nxt[i]   = '0;
            opening[i]   = bus.reach[i] && (frame_q[i] != FRAME_MAX);
            closing[i]   = !bus.reach[i] && (frame_q[i] != '0);
            if (opening[i] || closing[i]) begin
                if ((bus.reach[i] != reach_q[i]) && (div_q[i] != '0)) begin
                    div_nxt[i] = '0;
                end else if (div_q[i] == DIV_LAST) begin
                    div_nxt[i]   = '0;
                    frame_nxt[i] = opening[i] ? frame_q[i] + FW'(1) : frame_q[i] - FW'(1);
                end else begin
                    div_nxt[i] = div_q[i] + DW'(1);
                end
            end
        end
        // Uses the frame being written this tick, so the tick on which both
        // doors reach full open already counts toward the dwell.
        hold_ok = bus.reach[0] && bus.reach[1] &&
                  (frame_nxt[0] == FRAME_MAX) && (frame_nxt[1] == FRAME_MAX);
    end

    always_ff @(posedge frame_clk) begin
        if (RESET || bus.level_restart) begin
            state_q      <= PLAY;
            hold_q       <= '0;
            level_done_q <= 1'b0;
            complete_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                frame_q[i] <= '0;
                div_q[i]   <= '0;
                reach_q[i] <= 1'b0;
            end
        end else if (state_q == PLAY) begin
            if (!bus.pause) begin
                for (int i = 0; i < 2; i++) begin
                    frame_q[i] <= frame_nxt[i];
                    div_q[i]   <= div_nxt[i];
                    reach_q[i] <= bus.reach[i];
                end
                if (hold_ok) begin
                    if (hold_q == HOLD_LAST) begin
                        state_q      <= DONE;
                        level_done_q <= 1'b1;
                        complete_q   <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end else begin
                    hold_q <= '0;
                end
            end
        end else begin
            level_done_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                frame_q[i] <= FRAME_MAX;
                div_q[i]   <= '0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bus.door_frame[i] = frame_q[i];
        end
    end

    assign bus.level_done = level_done_q;
    assign bus.complete   = complete_q;

`ifdef LEVEL_TIMER_EN
    logic [5:0] tick_q;
    logic [9:0] elapsed_q;

    always_ff @(posedge frame_clk) begin
        if (RESET || bus.level_restart) begin
            tick_q    <= '0;
            elapsed_q <= '0;
        end else if ((state_q == PLAY) && !bus.pause) begin
            if (tick_q == 6'd59) begin
                tick_q <= '0;
                if (elapsed_q != 10'd999) begin
                    elapsed_q <= elapsed_q + 10'd1;
                end
            end else begin
                tick_q <= tick_q + 6'd1;
            end
        end
    end

    assign bus.elapsed_sec = elapsed_q;
`else
    assign bus.elapsed_sec = '0;
`endif
endmodule

// File: tb/tb_door_exit_ctrl.sv
// tb/tb_door_exit_ctrl.sv - directed self-checking bench for door_exit_ctrl
module tb_door_exit_ctrl;
    logic frame_clk;
    logic RESET;
    int   checks;
    int   errors;
    int   pulses;

    door_exit_ctrl_if #(.NUM_FRAMES(4)) bus ();

    door_exit_ctrl #(
        .NUM_FRAMES (4),
        .FRAME_DIV  (8),
        .HOLD_FRAMES(30)
    ) dut (
        .frame_clk(frame_clk),
        .RESET    (RESET),
        .bus      (bus)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit before sampling.
    task automatic step(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    task automatic set_reach(input logic r0, input logic r1);
        bus.reach[0] = r0;
        bus.reach[1] = r1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET = 1'b1;
        bus.pause = 1'b0;
        bus.level_restart = 1'b0;
        set_reach(1'b0, 1'b0);
        step(2);
        RESET = 1'b0;

        check("rst_f0", int'(bus.door_frame[0]), 0);
        check("rst_f1", int'(bus.door_frame[1]), 0);
        check("rst_done", int'(bus.level_done), 0);
        check("rst_cmpl", int'(bus.complete), 0);
        check("rst_sec", int'(bus.elapsed_sec), 0);

        // Door 0 opening alone
        set_reach(1'b1, 1'b0);
        step(7);  check("open_t7", int'(bus.door_frame[0]), 0);
        step(1);  check("open_t8", int'(bus.door_frame[0]), 1);
        step(8);  check("open_t16", int'(bus.door_frame[0]), 2);
        step(8);  check("open_t24", int'(bus.door_frame[0]), 3);
        step(16); check("open_sat", int'(bus.door_frame[0]), 3);
        check("open_f1", int'(bus.door_frame[1]), 0);
        check("open_cmpl", int'(bus.complete), 0);

        // Door 0 closing, with a mid-step reach toggle
        set_reach(1'b0, 1'b0);
        step(8);  check("close_t8", int'(bus.door_frame[0]), 2);
        step(4);
        set_reach(1'b1, 1'b0);
        step(1);  check("toggle_hi", int'(bus.door_frame[0]), 2);
        set_reach(1'b0, 1'b0);
        step(7);  check("toggle_restart", int'(bus.door_frame[0]), 2);
        step(1);  check("toggle_step", int'(bus.door_frame[0]), 1);
        step(8);  check("close_zero", int'(bus.door_frame[0]), 0);
        step(8);  check("close_sat", int'(bus.door_frame[0]), 0);

        // Pause mid-ramp
        do_reset();
        set_reach(1'b1, 1'b0);
        step(12); check("pause_pre", int'(bus.door_frame[0]), 1);
        bus.pause = 1'b1;
        step(10); check("pause_hold", int'(bus.door_frame[0]), 1);
        check("pause_sec", int'(bus.elapsed_sec), 0);
        bus.pause = 1'b0;
        step(3);  check("pause_resume3", int'(bus.door_frame[0]), 1);
        step(1);  check("pause_resume4", int'(bus.door_frame[0]), 2);

        // Both doors, clean dwell
        do_reset();
        set_reach(1'b1, 1'b1);
        step(23); check("both_t23", int'(bus.door_frame[1]), 2);
        step(1);  check("both_t24_f0", int'(bus.door_frame[0]), 3);
        check("both_t24_f1", int'(bus.door_frame[1]), 3);
        step(28); check("dwell_t52", int'(bus.level_done), 0);
        step(1);  check("dwell_t53_pulse", int'(bus.level_done), 1);
        check("dwell_t53_cmpl", int'(bus.complete), 1);
        step(1);  check("dwell_t54_pulse", int'(bus.level_done), 0);
        check("dwell_t54_cmpl", int'(bus.complete), 1);
        set_reach(1'b0, 1'b0);
        bus.pause = 1'b1;
        step(12); check("done_f0", int'(bus.door_frame[0]), 3);
        check("done_f1", int'(bus.door_frame[1]), 3);
        check("done_cmpl", int'(bus.complete), 1);
        bus.pause = 1'b0;
        bus.level_restart = 1'b1;
        step(1);  bus.level_restart = 1'b0;
        check("restart_cmpl", int'(bus.complete), 0);
        check("restart_f0", int'(bus.door_frame[0]), 0);
        check("restart_f1", int'(bus.door_frame[1]), 0);
        check("restart_sec", int'(bus.elapsed_sec), 0);

        // Glitch on reach[1] at hold_cnt = 20
        set_reach(1'b1, 1'b1);
        step(43);
        set_reach(1'b1, 1'b0);
        step(1);  check("glitch_f1", int'(bus.door_frame[1]), 3);
        set_reach(1'b1, 1'b1);
        pulses = 0;
        for (int k = 0; k < 29; k++) begin
            step(1);
            if (bus.level_done) pulses++;
        end
        check("glitch_early_pulses", pulses, 0);
        check("glitch_early_cmpl", int'(bus.complete), 0);
        step(1);  check("glitch_pulse", int'(bus.level_done), 1);
        check("glitch_cmpl", int'(bus.complete), 1);

        // RESET out of DONE
        RESET = 1'b1;
        step(1);  RESET = 1'b0;
        check("reset_done_cmpl", int'(bus.complete), 0);
        check("reset_done_f0", int'(bus.door_frame[0]), 0);

        // Pause on the transition tick blocks it; release completes
        set_reach(1'b1, 1'b1);
        step(52);
        bus.pause = 1'b1;
        step(1);  check("pause_tr_pulse", int'(bus.level_done), 0);
        check("pause_tr_cmpl", int'(bus.complete), 0);
        bus.pause = 1'b0;
        step(1);  check("pause_rel_pulse", int'(bus.level_done), 1);

        // Restart on the transition tick wins
        do_reset();
        step(52);
        bus.level_restart = 1'b1;
        step(1);  bus.level_restart = 1'b0;
        check("restart_tr_pulse", int'(bus.level_done), 0);
        check("restart_tr_cmpl", int'(bus.complete), 0);
        check("restart_tr_f0", int'(bus.door_frame[0]), 0);

`ifdef LEVEL_TIMER_EN
        do_reset();
        set_reach(1'b0, 1'b0);
        step(119); check("timer_119", int'(bus.elapsed_sec), 1);
        step(1);   check("timer_120", int'(bus.elapsed_sec), 2);
`else
        step(120); check("timer_off", int'(bus.elapsed_sec), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
